// File: rtl/spi_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one SPI master.
// Each grant strobes one word to the master, then tracks spi_cs until the transfer ends.
module spi_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 12,
  parameter int unsigned START_TO = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               err,
  output logic               busy,
  output logic               spi_newd,
  output logic [DW-1:0]      spi_din,
  input  logic               spi_cs
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [CW-1:0] CntLast = CW'(START_TO - 1);

  typedef enum logic [1:0] {StIdle, StWaitStart, StWaitEnd} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              newd_q, newd_d;
  logic [DW-1:0]     din_q, din_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [IW-1:0]     win;
  logic [IW-1:0]     idx;
  logic              found;

  // Search upward from last+1, wrapping, so the previous winner is considered last.
  always_comb begin
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IW'((32'(last_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    newd_d  = 1'b0;
    din_d   = din_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = NREQ'(1) << win;
          newd_d  = 1'b1;
          din_d   = req_data[win*DW +: DW];
          owner_d = win;
          cnt_d   = '0;
          state_d = StWaitStart;
        end
      end
      StWaitStart: begin
        if (!spi_cs) begin
          state_d = StWaitEnd;
        end else if (cnt_q == CntLast) begin
          // Master never started: report and give up without touching last.
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWaitEnd: begin
        if (spi_cs) begin
          done_d  = NREQ'(1) << owner_q;
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      newd_q  <= 1'b0;
      din_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      newd_q  <= newd_d;
      din_q   <= din_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign spi_newd = newd_q;
  assign spi_din  = din_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: expected grants/completions are queued as stimulus
// is driven and popped by monitors when the DUT pulses spi_newd or done.
module tb_spi_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned DW       = 12;
  localparam int unsigned START_TO = 64;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   din;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic               busy;
  logic               spi_newd;
  logic [DW-1:0]      spi_din;
  logic               spi_cs = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t            exp_q[$];
  logic [NREQ-1:0] exp_done_q[$];
  logic [DW-1:0]   words[NREQ];

  spi_arbiter #(
    .NREQ     (NREQ),
    .DW       (DW),
    .START_TO (START_TO)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .spi_newd (spi_newd),
    .spi_din  (spi_din),
    .spi_cs   (spi_cs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_words();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = words[i];
  endtask

  task automatic push_grant(input int w);
    exp_t e;
    e.gnt = NREQ'(1) << w;
    e.din = words[w];
    exp_q.push_back(e);
    exp_done_q.push_back(NREQ'(1) << w);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    spi_cs = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_newd(output int n);
    bit got = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      n++;
      if (spi_newd) got = 1'b1;
    end
    if (!got) check_eq("newd_timeout", spi_newd, 1);
  endtask

  // Master model: cs low lo cycles after the strobe, high again hi cycles later.
  task automatic serve(input int lo, input int hi, input bit drop, output int gap);
    wait_newd(gap);
    if (drop) req = '0;
    repeat (lo) @(negedge clk);
    spi_cs = 1'b0;
    repeat (hi) @(negedge clk);
    spi_cs = 1'b1;
  endtask

  // Grant monitor: every strobe must match the oldest expected grant.
  always @(negedge clk) begin
    if (spi_newd || gnt != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_gnt", gnt, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("gnt", gnt, e.gnt);
        check_eq("newd_with_gnt", spi_newd, 1);
        check_eq("din", spi_din, e.din);
      end
    end
  end

  always @(negedge clk) begin
    if (done != '0) begin
      if (exp_done_q.size() == 0) check_eq("unexpected_done", done, 0);
      else check_eq("done", done, exp_done_q.pop_front());
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int n;
    int cnt_g;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_newd", spi_newd, 0);
    check_eq("rst_din", spi_din, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single transfer from requester 2
    words = '{12'h111, 12'h222, 12'hA5C, 12'h444};
    load_words();
    req = 4'b0100;
    push_grant(2);
    wait_newd(n);
    check_eq("latency", n, 1);
    req = '0;
    repeat (5) @(negedge clk);
    spi_cs = 1'b0;
    check_eq("busy_mid", busy, 1);
    repeat (26) @(negedge clk);
    spi_cs = 1'b1;
    @(negedge clk);
    check_eq("done2", done, 4'b0100);
    check_eq("busy_after", busy, 0);
    check_eq("din_hold", spi_din, 12'hA5C);
    repeat (2) @(negedge clk);

    // All requesters held high: strict rotation 0,1,2,3,0
    do_reset();
    words = '{12'h101, 12'h202, 12'h303, 12'h404};
    load_words();
    for (int k = 0; k < 5; k++) push_grant(k % NREQ);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(2, 3, k == 4, gap);
      if (k > 0) check_eq("rr_gap", gap, 2);
    end
    repeat (3) @(negedge clk);

    // Start timeout
    do_reset();
    req = 4'b0001;
    begin
      exp_t e;
      e.gnt = 4'b0001;
      e.din = words[0];
      exp_q.push_back(e);
    end
    wait_newd(n);
    req = '0;
    n = 0;
    for (int k = 0; k < 100 && !err; k++) begin
      @(negedge clk);
      n++;
    end
    check_eq("err_delay", n, START_TO);
    check_eq("err_pulse", err, 1);
    check_eq("err_no_done", done, 0);
    check_eq("err_idle", busy, 0);
    @(negedge clk);
    check_eq("err_one_cycle", err, 0);
    req = 4'b1111;
    push_grant(0);
    serve(1, 1, 1'b1, gap);
    repeat (3) @(negedge clk);

    // Reset during WAIT_END aborts the transfer silently
    do_reset();
    req = 4'b0001;
    begin
      exp_t e;
      e.gnt = 4'b0001;
      e.din = words[0];
      exp_q.push_back(e);
    end
    wait_newd(n);
    req = '0;
    repeat (2) @(negedge clk);
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    spi_cs = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_newd", spi_newd, 0);
    check_eq("abort_din", spi_din, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_err", err, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_done2", done, 0);
    req = 4'b0010;
    push_grant(1);
    serve(1, 2, 1'b1, gap);
    repeat (3) @(negedge clk);

    // Request raised and dropped outside IDLE is ignored
    req = 4'b0001;
    push_grant(0);
    wait_newd(n);
    req = '0;
    repeat (2) @(negedge clk);
    spi_cs = 1'b0;
    @(negedge clk);
    req = 4'b1000;
    repeat (3) @(negedge clk);
    req = '0;
    @(negedge clk);
    spi_cs = 1'b1;
    cnt_g = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt != '0) cnt_g++;
    end
    check_eq("ignored_req", cnt_g, 0);

    // Two requesters alternate
    words = '{12'h0AA, 12'h1BB, 12'h2CC, 12'h3DD};
    load_words();
    push_grant(1);
    push_grant(3);
    push_grant(1);
    push_grant(3);
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      serve(1, 3, k == 3, gap);
      if (k > 0) check_eq("alt_gap", gap, 2);
    end
    repeat (5) @(negedge clk);

    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("exp_done_empty", exp_done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL provide parameter NREQ, default 4: number of requesters sharing one spi master.
REQ-002 The block SHALL provide parameter DW, default 12: width of spi_din and of each requester word.
REQ-003 The block SHALL provide parameter START_TO, default 64: clk cycles allowed from spi_newd until spi_cs falls.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL provide port rst, input, 1 bit: reset that is synchronous and active-low.
REQ-006 The block SHALL provide port req, input, NREQ bits: per-requester transfer request level.
REQ-007 The block SHALL provide port req_data, input, NREQ*DW bits: requester i word at bits [i*DW +: DW].
REQ-008 The block SHALL provide port gnt, output, NREQ bits: one-cycle acceptance pulse, one-hot.
REQ-009 The block SHALL provide port done, output, NREQ bits: one-cycle completion pulse, one-hot.
REQ-010 The block SHALL provide port err, output, 1 bit: one-cycle start-timeout pulse.
REQ-011 The block SHALL provide port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 The block SHALL provide port spi_newd, output, 1 bit: new-data strobe to the spi master.
REQ-013 The block SHALL provide port spi_din, output, DW bits: word presented to the spi master.
REQ-014 The block SHALL provide port spi_cs, input, 1 bit: chip select from the spi master; 1 = idle, 0 = transferring.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT_START and WAIT_END.
REQ-016 IDLE: if req is nonzero, the block SHALL select winner w by round-robin, searching upward from last+1 mod NREQ, where last is the previous winner.
REQ-017 On the edge that leaves IDLE, the block SHALL register gnt[w]=1, spi_newd=1, spi_din=req_data word w, owner=w, clear the timeout counter, and enter WAIT_START.
REQ-018 gnt and spi_newd SHALL be high for exactly one cycle and coincident, giving request-to-strobe latency of 1 clk.
REQ-019 spi_din SHALL hold the granted word unchanged until the next grant.
REQ-020 WAIT_START: spi_cs==0 SHALL move the FSM to WAIT_END; otherwise the counter SHALL increment.
REQ-021 When the counter reaches START_TO-1 with spi_cs still 1, the block SHALL pulse err, leave last unchanged, and return to IDLE without a done pulse.
REQ-022 WAIT_END: spi_cs==1 SHALL pulse done[owner] for one cycle, set last=owner, and return to IDLE.
REQ-023 Minimum spacing between successive spi_newd pulses SHALL be 1 IDLE cycle; back-to-back requests SHALL arbitrate on that IDLE cycle.
REQ-024 Changes to req and req_data outside IDLE SHALL be ignored; a req that drops before it is sampled in IDLE SHALL receive no grant.
REQ-025 A requester holding req high after its gnt SHALL be treated as a new request.
REQ-026 Round-robin SHALL be starvation-free: with all req high, grant order SHALL be 0,1,2,3,0,...
REQ-027 The counter SHALL be $clog2(START_TO) bits wide and SHALL saturate rather than wrap.

Reset
REQ-028 When rst==0 at a clk edge, the next state SHALL be IDLE regardless of current state, including mid-transfer.
REQ-029 On that reset, outputs SHALL be: gnt=0, done=0, err=0, busy=0, spi_newd=0, spi_din=0.
REQ-030 On that reset, internal state SHALL be: counter=0, owner=0, last=NREQ-1, so requester 0 wins first.
REQ-031 A transfer aborted by reset SHALL produce no done and no err pulse.

Verification
REQ-032 req=4'b0100, data2=12'hA5C, spi_cs pulled low 5 cycles after strobe, high 26 cycles later -> gnt=4'b0100 and spi_newd=1 one clk after req, spi_din=12'hA5C, done=4'b0100 one clk after cs rises, busy low.
REQ-033 req=4'b1111 held, master model completing each transfer -> grant order 0,1,2,3,0 with exactly one gnt and one done per transfer.
REQ-034 req=4'b0001, spi_cs held at 1 -> err pulses 64 cycles after spi_newd, no done, FSM in IDLE, next grant goes to requester 0 again.
REQ-035 rst=0 asserted during WAIT_END -> next cycle busy=0, spi_newd=0, spi_din=0, no done; subsequent req=4'b0010 is granted normally.
REQ-036 req=4'b0001 granted, then req=4'b1000 raised and dropped during WAIT_END -> no gnt[3] after return to IDLE.
REQ-037 Two requesters (1 and 3) hold req high -> grants alternate 1,3,1,3 with one IDLE cycle between done and the next spi_newd.
